// File: rtl/psk_symbol_packer.sv
// psk_symbol_packer: byte AXI-Stream to PSK symbol serializer (QPSK 2 bits, BPSK 1 bit duplicated),
// with one-byte prefetch. Define PSK_SCRAMBLER_EN to add the x^7+x^4+1 additive scrambler.
module psk_symbol_packer #(
   parameter int         BYTES    = 1,
   parameter logic [6:0] SCR_SEED = 7'h7F
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_enable,
   input  logic [7:0]         s_tdata,
   input  logic               s_tvalid,
   output logic               s_tready,
   input  logic               s_tlast,
   input  logic               s_tuser,
   output logic [8*BYTES-1:0] m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               m_tlast,
   output logic               m_tuser,
   output logic               underrun
);
   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
   state_t state, state_n;

   logic [7:0] sr, sr_n, pb, pb_n;
   logic       sr_mode, sr_mode_n, sr_last, sr_last_n;
   logic       pb_full, pb_full_n, pb_mode, pb_mode_n, pb_last, pb_last_n, pb_first, pb_first_n;
   logic [2:0] sym_cnt, sym_cnt_n;
   logic       mode, mode_n, in_frame, in_frame_n;
   logic [1:0] sym, sym_n, ks;
   logic       m_tvalid_n, m_tlast_n, m_tuser_n, s_tready_n, underrun_n;
   logic       in_fire, out_fire, last_sym, byte_mode, byte_first, load_sr_in, load_sr_pb;

   function automatic logic [2:0] max_cnt(input logic bpsk);
      return bpsk ? 3'd7 : 3'd3;
   endfunction

   function automatic logic [1:0] sym_bits(input logic [7:0] b, input logic [2:0] k,
                                           input logic bpsk);
      logic [7:0] sh;
      if (bpsk) begin
         sh = b << k;
         return {sh[7], sh[7]};
      end else begin
         sh = b << {k[1:0], 1'b0};
         return sh[7:6];
      end
   endfunction

   assign m_tdata = {{(8*BYTES-2){1'b0}}, sym};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else if (clk_enable) state <= state_n;
   end

   // next state plus SR load decode; PB moves into SR on the cycle SR's last symbol is taken
   always_comb begin
      in_fire    = clk_enable & s_tvalid & s_tready;
      out_fire   = clk_enable & m_tvalid & m_tready;
      last_sym   = (sym_cnt == max_cnt(sr_mode));
      byte_mode  = in_frame ? mode : s_tuser;
      byte_first = ~in_frame;
      load_sr_in = 1'b0;
      load_sr_pb = 1'b0;
      state_n    = state;
      case (state)
         IDLE: begin
            if (in_fire) begin
               load_sr_in = 1'b1;
               state_n    = ACTIVE;
            end else begin
               state_n = IDLE;
            end
         end
         ACTIVE: begin
            if (out_fire && last_sym) begin
               if (pb_full) load_sr_pb = 1'b1;
               else if (in_fire) load_sr_in = 1'b1;
               else state_n = IDLE;
            end else begin
               state_n = ACTIVE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // datapath next values: SR, prefetch buffer, symbol counter, frame/mode latch
   always_comb begin
      sr_n = sr;  sr_mode_n = sr_mode;  sr_last_n = sr_last;  sym_cnt_n = sym_cnt;
      pb_n = pb;  pb_mode_n = pb_mode;  pb_last_n = pb_last;  pb_first_n = pb_first;
      pb_full_n = pb_full;  mode_n = mode;  in_frame_n = in_frame;
      if (load_sr_pb) begin
         sr_n = pb;  sr_mode_n = pb_mode;  sr_last_n = pb_last;  sym_cnt_n = 3'd0;
         pb_full_n = 1'b0;
      end else if (load_sr_in) begin
         sr_n = s_tdata;  sr_mode_n = byte_mode;  sr_last_n = s_tlast;  sym_cnt_n = 3'd0;
      end else if (out_fire) begin
         sym_cnt_n = last_sym ? 3'd0 : sym_cnt + 3'd1;
      end else begin
         sym_cnt_n = sym_cnt;
      end
      if (in_fire && !load_sr_in) begin
         pb_n = s_tdata;  pb_mode_n = byte_mode;  pb_last_n = s_tlast;  pb_first_n = byte_first;
         pb_full_n = 1'b1;
      end else begin
         pb_full_n = pb_full_n;
      end
      if (in_fire) begin
         mode_n     = in_frame ? mode : s_tuser;
         in_frame_n = ~s_tlast;
      end else begin
         in_frame_n = in_frame;
      end
   end

`ifdef PSK_SCRAMBLER_EN
   logic [6:0] scr, scr_n;

   function automatic logic [6:0] scr_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[3]};
   endfunction

   function automatic logic scr_fb(input logic [6:0] s);
      return s[6] ^ s[3];
   endfunction

   // scrambler state is aligned to the first bit of the presented symbol; reseeded per frame
   always_comb begin
      if ((load_sr_in && byte_first) || (load_sr_pb && pb_first)) scr_n = SCR_SEED;
      else if (out_fire) scr_n = sr_mode ? scr_step(scr) : scr_step(scr_step(scr));
      else scr_n = scr;
      ks = sr_mode_n ? {2{scr_fb(scr_n)}} : {scr_fb(scr_n), scr_fb(scr_step(scr_n))};
   end

   // scrambler register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scr <= SCR_SEED;
      else if (clk_enable) scr <= scr_n;
   end
`else
   // no keystream
   always_comb ks = 2'b00;
`endif

   // output next values derived from next state, so outputs stay registered with no extra latency
   always_comb begin
      m_tvalid_n = (state_n == ACTIVE);
      sym_n      = m_tvalid_n ? (sym_bits(sr_n, sym_cnt_n, sr_mode_n) ^ ks) : 2'b00;
      m_tlast_n  = m_tvalid_n & sr_last_n & (sym_cnt_n == max_cnt(sr_mode_n));
      m_tuser_n  = m_tvalid_n & sr_mode_n;
      s_tready_n = ~pb_full_n;
      underrun_n = underrun | (clk_enable & m_tready & ~m_tvalid & in_frame);
   end

   // datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= 8'h00;  sr_mode <= 1'b0;  sr_last <= 1'b0;  sym_cnt <= 3'd0;
         pb <= 8'h00;  pb_mode <= 1'b0;  pb_last <= 1'b0;  pb_first <= 1'b0;  pb_full <= 1'b0;
         mode <= 1'b0;  in_frame <= 1'b0;
         sym <= 2'b00;  m_tvalid <= 1'b0;  m_tlast <= 1'b0;  m_tuser <= 1'b0;
         s_tready <= 1'b0;  underrun <= 1'b0;
      end else if (clk_enable) begin
         sr <= sr_n;  sr_mode <= sr_mode_n;  sr_last <= sr_last_n;  sym_cnt <= sym_cnt_n;
         pb <= pb_n;  pb_mode <= pb_mode_n;  pb_last <= pb_last_n;  pb_first <= pb_first_n;
         pb_full <= pb_full_n;  mode <= mode_n;  in_frame <= in_frame_n;
         sym <= sym_n;  m_tvalid <= m_tvalid_n;  m_tlast <= m_tlast_n;  m_tuser <= m_tuser_n;
         s_tready <= s_tready_n;  underrun <= underrun_n;
      end
   end
endmodule

// File: tb/tb_psk_symbol_packer.sv
// Scoreboard bench for psk_symbol_packer: accepted bytes are expanded into expected symbols,
// popped when the modulator side takes a symbol. Scrambler expectations follow PSK_SCRAMBLER_EN.
module tb_psk_symbol_packer;
   typedef logic [3:0] exp_t;   // {sym[1:0], last, user}

   logic       clk = 1'b0, rst_n = 1'b0, clk_enable = 1'b0;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b0;
   logic       s_tready, m_tvalid, m_tlast, m_tuser, underrun;
   logic [7:0] m_tdata;

   int   checks = 0, failures = 0;
   exp_t sb[$];
   exp_t obs[$];
   exp_t mon_got, mon_exp;
   logic mdl_in_frame = 1'b0, mdl_mode = 1'b0;
   logic [7:1] mdl_s = 7'h7F;

   psk_symbol_packer #(.BYTES(1), .SCR_SEED(7'h7F)) dut (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .s_tuser(s_tuser), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tuser(m_tuser), .underrun(underrun));

   always #5 clk = ~clk;

   function automatic logic next_ks();
`ifdef PSK_SCRAMBLER_EN
      logic fb;
      fb    = mdl_s[7] ^ mdl_s[4];
      mdl_s = {mdl_s[6:1], fb};
      return fb;
`else
      return 1'b0;
`endif
   endfunction

   // expand one accepted byte into expected symbols, in transmit order
   task automatic model_push(input logic [7:0] d, input logic user, input logic last);
      logic [1:0] sy;
      logic       b;
      int         n;
      if (!mdl_in_frame) begin
         mdl_mode = user;
         mdl_s    = 7'h7F;
      end
      mdl_in_frame = !last;
      n = mdl_mode ? 8 : 4;
      for (int k = 0; k < n; k++) begin
         if (mdl_mode) begin
            b  = d[7-k] ^ next_ks();
            sy = {b, b};
         end else begin
            sy[1] = d[7-2*k] ^ next_ks();
            sy[0] = d[6-2*k] ^ next_ks();
         end
         sb.push_back({sy, last && (k == n - 1), mdl_mode});
      end
   endtask

   // output monitor: every symbol transfer is checked against the scoreboard head
   always begin
      @(negedge clk);
      #2;
      if (rst_n && clk_enable && m_tvalid && m_tready) begin
         mon_got = {m_tdata[1:0], m_tlast, m_tuser};
         obs.push_back(mon_got);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sym_unexpected: got {sym,last,user}=%b, none expected", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL sym: got {sym,last,user}=%b required %b", mon_got, mon_exp);
            end
         end
         checks++;
         if (m_tdata[7:2] !== 6'd0) begin
            failures++;
            $display("FAIL tdata_upper: got %h required 00", m_tdata[7:2]);
         end
      end
   end

   // drive one byte from a negedge; returns at the negedge after it is accepted
   task automatic send_byte(input logic [7:0] d, input logic user, input logic last,
                            input bit keep_valid);
      bit acc = 1'b0;
      s_tdata = d;  s_tuser = user;  s_tlast = last;  s_tvalid = 1'b1;
      for (int i = 0; i < 400 && !acc; i++) begin
         #2;
         if (s_tready && clk_enable) begin
            model_push(d, user, last);
            acc = 1'b1;
         end
         @(negedge clk);
      end
      if (!keep_valid) s_tvalid = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL accept_timeout: byte %h not accepted, required acceptance", d);
      end
   endtask

   task automatic strobe(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         m_tready = 1'b1;
         @(negedge clk);
         m_tready = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, s_tready, underrun, m_tdata} !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 0", {m_tvalid, m_tlast, m_tuser, s_tready,
                  underrun, m_tdata});
      end
      rst_n = 1'b1;
      clk_enable = 1'b1;
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b required 1", s_tready);
      end
   endtask

   task automatic test_qpsk_single();
      exp_t e[4];
      obs.delete();
      fork
         send_byte(8'hB4, 1'b0, 1'b1, 1'b0);
         strobe(6, 16);
      join
`ifndef PSK_SCRAMBLER_EN
      e = '{4'b1000, 4'b1100, 4'b0100, 4'b0010};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs.size() <= i || obs[i] !== e[i]) begin
            failures++;
            $display("FAIL qpsk_sym%0d: got %b required %b", i, obs[i], e[i]);
         end
      end
`endif
      checks++;
      if (sb.size() != 0 || underrun !== 1'b0) begin
         failures++;
         $display("FAIL qpsk_end: got pending=%0d underrun=%b required 0/0", sb.size(), underrun);
      end
   endtask

   task automatic test_bpsk_hold();
      exp_t e[8];
      logic [7:0] held;
      obs.delete();
      send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
      held = m_tdata;
      clk_enable = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
      clk_enable = 1'b1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== held) begin
         failures++;
         $display("FAIL enable_hold: got valid=%b data=%h required 1/%h", m_tvalid, m_tdata, held);
      end
      strobe(9, 4);
`ifndef PSK_SCRAMBLER_EN
      e = '{4'b1101, 4'b0001, 4'b1101, 4'b0001, 4'b0001, 4'b1101, 4'b0001, 4'b1111};
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs.size() <= i || obs[i] !== e[i]) begin
            failures++;
            $display("FAIL bpsk_sym%0d: got %b required %b", i, obs[i], e[i]);
         end
      end
`endif
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL bpsk_end: got pending=%0d required 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int gaps = 0;
      bit ready_low = 1'b0, seen = 1'b0;
      obs.delete();
      m_tready = 1'b1;
      fork
         begin
            send_byte(8'h1E, 1'b0, 1'b0, 1'b1);
            send_byte(8'hC3, 1'b1, 1'b0, 1'b1);
            send_byte(8'h5A, 1'b0, 1'b1, 1'b0);
         end
         begin
            for (int i = 0; i < 20 && !seen; i++) begin
               #2;
               if (m_tvalid) seen = 1'b1;
               else @(negedge clk);
            end
            for (int i = 0; i < 12; i++) begin
               if (!m_tvalid) gaps++;
               if (!s_tready) ready_low = 1'b1;
               @(negedge clk);
               #2;
            end
         end
      join
      drain(40);
      m_tready = 1'b0;
      checks++;
      if (!seen || gaps != 0) begin
         failures++;
         $display("FAIL b2b_gaps: got seen=%b gaps=%0d required 1/0", seen, gaps);
      end
      checks++;
      if (!ready_low) begin
         failures++;
         $display("FAIL b2b_ready_low: got never-low required low while prefetch full");
      end
      checks++;
      if (obs.size() != 12 || sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_count: got %0d pending=%0d required 12/0", obs.size(), sb.size());
      end
      foreach (obs[i]) begin
         checks++;
         if (obs[i][0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tuser%0d: got %b required 0", i, obs[i][0]);
         end
      end
      checks++;
      if (underrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_underrun: got %b required 0", underrun);
      end
   endtask

   task automatic test_underrun();
      fork
         begin
            send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
            repeat (90) @(negedge clk);
            send_byte(8'h81, 1'b0, 1'b1, 1'b0);
         end
         for (int i = 0; i < 13; i++) begin
            m_tready = 1'b1;
            #2;
            if (i == 5) begin
               checks++;
               if (m_tvalid !== 1'b0 || underrun !== 1'b0) begin
                  failures++;
                  $display("FAIL stall_state: got valid=%b underrun=%b required 0/0", m_tvalid,
                           underrun);
               end
            end
            @(negedge clk);
            m_tready = 1'b0;
            if (i == 5) begin
               checks++;
               if (underrun !== 1'b1) begin
                  failures++;
                  $display("FAIL underrun_set: got %b required 1", underrun);
               end
            end
            repeat (15) @(negedge clk);
         end
      join
      checks++;
      if (underrun !== 1'b1 || sb.size() != 0) begin
         failures++;
         $display("FAIL underrun_end: got underrun=%b pending=%0d required 1/0", underrun,
                  sb.size());
      end
   endtask

   task automatic test_reset_mid_byte();
      exp_t e[4];
      send_byte(8'h6C, 1'b0, 1'b1, 1'b0);
      m_tready = 1'b1;
      repeat (2) @(negedge clk);
      m_tready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, s_tready, underrun, m_tdata} !== 13'd0) begin
         failures++;
         $display("FAIL async_reset: got %b required 0", {m_tvalid, m_tlast, m_tuser, s_tready,
                  underrun, m_tdata});
      end
      sb.delete();
      mdl_in_frame = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      obs.delete();
      m_tready = 1'b1;
      send_byte(8'h6C, 1'b0, 1'b1, 1'b0);
      drain(20);
      m_tready = 1'b0;
`ifndef PSK_SCRAMBLER_EN
      e = '{4'b0100, 4'b1000, 4'b1100, 4'b0010};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs.size() <= i || obs[i] !== e[i]) begin
            failures++;
            $display("FAIL restart_sym%0d: got %b required %b", i, obs[i], e[i]);
         end
      end
`endif
      checks++;
      if (sb.size() != 0 || underrun !== 1'b0) begin
         failures++;
         $display("FAIL restart_end: got pending=%0d underrun=%b required 0/0", sb.size(),
                  underrun);
      end
   endtask

   task automatic test_scrambler();
      exp_t e[4];
`ifdef PSK_SCRAMBLER_EN
      e = '{4'b0000, 4'b0000, 4'b1100, 4'b1010};
`else
      e = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
`endif
      obs.delete();
      m_tready = 1'b1;
      send_byte(8'h00, 1'b0, 1'b1, 1'b1);
      send_byte(8'h00, 1'b0, 1'b1, 1'b0);
      drain(30);
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs.size() <= i || obs[i] !== e[i % 4]) begin
            failures++;
            $display("FAIL scr_sym%0d: got %b required %b", i, obs[i], e[i % 4]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_qpsk_single();
      test_bpsk_hold();
      test_back_to_back();
      test_underrun();
      test_reset_mid_byte();
      test_scrambler();
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
